// File: rtl/i2s_master_tx_if.sv
// Purpose: parallel-sample handshake and serial I2S outputs of the I2S master transmitter.
// Latency: none, this is a plain bundle of wires.
// Backpressure: iValid/oReady handshake; a transfer happens when both are high at a clock edge.
interface i2s_master_tx_if #(
  parameter int WS = 16
);
  logic [WS-1:0] iL;
  logic [WS-1:0] iR;
  logic          iValid;
  logic          oReady;
  logic          oBCLK;
  logic          oLRCK;
  logic          oDAT;
  logic          oUnderrun;
  logic [7:0]    oUnderCnt;

  // Transmitter side: consumes samples, drives the serial bus and status.
  modport master (
    input  iL, iR, iValid,
    output oReady, oBCLK, oLRCK, oDAT, oUnderrun, oUnderCnt
  );

  // Sample source / serial-bus observer side.
  modport slave (
    output iL, iR, iValid,
    input  oReady, oBCLK, oLRCK, oDAT, oUnderrun, oUnderCnt
  );
endinterface

// File: rtl/i2s_master_tx.sv
// Purpose: I2S bus master transmitter; generates BCLK/LRCK and shifts stereo samples out MSB-first.
// Latency: an accepted sample goes out from the next frame start, at most one frame plus one BCLK.
// Backpressure: one holding register; oReady stays low from accept until the next frame-start load.
module i2s_master_tx #(
  parameter int BCLK_DIV = 8,
  parameter int WS       = 16,
  parameter int I2S_MODE = 1
) (
  input logic             iCLK_50,
  input logic             iRST_N,
  i2s_master_tx_if.master bus
);

  localparam int            DW       = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  // Bit-clock generator state
  logic [DW-1:0] divCnt;
  logic          bclk;

  // Frame position and serial outputs
  logic [5:0]    bitCnt;
  logic          lrck;
  logic          dat;

  // Sample storage: holding register fed by the handshake, shift pair feeding the wire
  logic [WS-1:0] holdL;
  logic [WS-1:0] holdR;
  logic          holdFull;
  logic [WS-1:0] shiftL;
  logic [WS-1:0] shiftR;

  // Underrun status
  logic          underrun;
  logic [7:0]    underCnt;

  // Combinational helpers
  logic          divWrap;
  logic          fallEv;
  logic          frameStart;
  logic          loadHold;
  logic          accept;
  logic [5:0]    bitCntNxt;
  logic [WS-1:0] shiftLNxt;
  logic [WS-1:0] shiftRNxt;
  logic [WS-1:0] sampleNxt;
  logic [31:0]   aligned;
  logic [4:0]    slotPos;
  logic [4:0]    slotPosM1;
  logic          datNxt;

  assign divWrap    = (divCnt == DIV_LAST);
  // A fall event is the divider wrap while BCLK is high: BCLK goes 1->0 on this clock.
  assign fallEv     = divWrap & bclk;
  assign bitCntNxt  = bitCnt + 6'd1;
  assign frameStart = fallEv & (bitCnt == 6'd63);
  assign loadHold   = frameStart & holdFull;
  assign accept     = bus.iValid & ~holdFull;

  // The data bit launched on a frame-start fall must come from the freshly loaded sample,
  // so the serializer looks at the next-state shift registers rather than the current ones.
  assign shiftLNxt  = loadHold ? holdL : shiftL;
  assign shiftRNxt  = loadHold ? holdR : shiftR;

  // Select the bit for the upcoming slot position; left-aligning the sample into 32 bits
  // makes every position past the sample width read as zero without range checks.
  always_comb begin
    sampleNxt = bitCntNxt[5] ? shiftRNxt : shiftLNxt;
    aligned   = 32'(sampleNxt) << (32 - WS);
    slotPos   = bitCntNxt[4:0];
    slotPosM1 = slotPos - 5'd1;
    datNxt    = 1'b0;
    if (I2S_MODE != 0) begin
      // I2S: one BCLK of delay after the LRCK edge, so position 0 is always idle.
      if (slotPos != 5'd0) begin
        datNxt = aligned[5'd31 - slotPosM1];
      end
    end else begin
      // Left-justified: MSB sits at position 0 of the slot.
      datNxt = aligned[5'd31 - slotPos];
    end
  end

  // BCLK divider: toggle BCLK every BCLK_DIV system clocks.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      divCnt <= '0;
      bclk   <= 1'b0;
    end else if (divWrap) begin
      divCnt <= '0;
      bclk   <= ~bclk;
    end else begin
      divCnt <= divCnt + DW'(1);
    end
  end

  // Frame position, word select and serial data all advance on BCLK falling edges only.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      bitCnt <= 6'd63;
      lrck   <= 1'b1;
      dat    <= 1'b0;
    end else if (fallEv) begin
      bitCnt <= bitCntNxt;
      lrck   <= bitCntNxt[5];
      dat    <= datNxt;
    end
  end

  // Holding register: capture on handshake, release into the shift pair at frame start.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      holdL    <= '0;
      holdR    <= '0;
      holdFull <= 1'b0;
    end else if (accept) begin
      holdL    <= bus.iL;
      holdR    <= bus.iR;
      holdFull <= 1'b1;
    end else if (loadHold) begin
      holdFull <= 1'b0;
    end
  end

  // Shift pair: reloaded only at a frame start with a full holding register, else repeats.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      shiftL <= '0;
      shiftR <= '0;
    end else begin
      shiftL <= shiftLNxt;
      shiftR <= shiftRNxt;
    end
  end

  // Underrun flag pulses for one clock per starved frame start; the counter saturates.
  always_ff @(posedge iCLK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      underrun <= 1'b0;
      underCnt <= 8'd0;
    end else begin
      underrun <= frameStart & ~holdFull;
      if (frameStart && !holdFull && (underCnt != 8'hFF)) begin
        underCnt <= underCnt + 8'd1;
      end
    end
  end

  assign bus.oReady    = ~holdFull;
  assign bus.oBCLK     = bclk;
  assign bus.oLRCK     = lrck;
  assign bus.oDAT      = dat;
  assign bus.oUnderrun = underrun;
  assign bus.oUnderCnt = underCnt;

endmodule
